apb_requester_mux: RTL and testbench

APB_REQUESTER_MUX -- requirements
Module: apb_requester_mux

---
 rtl/apb_requester_mux.sv | 147 ++++++++++++++
 tb/tb_apb_requester_mux.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_requester_mux.sv
// Single-command APB requester that routes each transfer to one of NUM_SLAVES peripherals
// by an address field, with decode-error and wait-state timeout reporting.
module apb_requester_mux #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned SEL_LSB        = 12,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                             pclk,
  input  logic                             preset,
  // Command channel
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_write,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [DATA_WIDTH-1:0]            req_wdata,
  input  logic [STRB_WIDTH-1:0]            req_strb,
  input  logic [2:0]                       req_prot,
  // Response channel
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic                             rsp_timeout,
  // Shared APB bus
  output logic [ADDR_WIDTH-1:0]            paddr,
  output logic                             pwrite,
  output logic [DATA_WIDTH-1:0]            pwdata,
  output logic [STRB_WIDTH-1:0]            pstrb,
  output logic [2:0]                       pprot,
  output logic                             penable,
  output logic [NUM_SLAVES-1:0]            psel,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]            pready,
  input  logic [NUM_SLAVES-1:0]            pslverr
);

  localparam int unsigned IdxW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e state_q, state_d;

  logic [IdxW-1:0]       idx_q;
  logic [IdxW-1:0]       req_idx;
  logic                  write_q;
  logic [7:0]            wait_q;
  logic                  decode_err;
  logic                  bus_active;
  logic                  sel_ready;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  timeout_hit;

  assign req_idx    = req_addr[SEL_LSB +: IdxW];
  assign decode_err = {{(32 - IdxW){1'b0}}, req_idx} >= NUM_SLAVES;

  // Returns from the selected slave only; everything else on the bus is ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (idx_q == IdxW'(i)) begin
        sel_ready = pready[i];
        sel_err   = pslverr[i];
        sel_rdata = prdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign timeout_hit = !sel_ready && (wait_q == 8'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (req_valid) state_d = decode_err ? StResp : StSetup;
      StSetup:  state_d = StAccess;
      StAccess: if (sel_ready || timeout_hit) state_d = StResp;
      StResp:   if (rsp_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      idx_q       <= '0;
      write_q     <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      pstrb       <= '0;
      pprot       <= '0;
      wait_q      <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      if (state_q == StIdle && req_valid) begin
        if (decode_err) begin
          rsp_rdata   <= '0;
          rsp_err     <= 1'b1;
          rsp_timeout <= 1'b0;
        end else begin
          idx_q   <= req_idx;
          write_q <= req_write;
          paddr   <= req_addr;
          pwdata  <= req_wdata;
          pstrb   <= req_strb;
          pprot   <= req_prot;
          wait_q  <= '0;
        end
      end
      if (state_q == StAccess) begin
        if (sel_ready) begin
          rsp_rdata   <= write_q ? '0 : sel_rdata;
          rsp_err     <= sel_err;
          rsp_timeout <= 1'b0;
        end else if (timeout_hit) begin
          rsp_rdata   <= '0;
          rsp_err     <= 1'b1;
          rsp_timeout <= 1'b1;
        end else begin
          wait_q <= wait_q + 8'd1;
        end
      end
    end
  end

  assign bus_active = (state_q == StSetup) || (state_q == StAccess);
  assign penable    = (state_q == StAccess);
  assign pwrite     = bus_active && write_q;
  assign req_ready  = (state_q == StIdle);
  assign rsp_valid  = (state_q == StResp);

  always_comb begin
    psel = '0;
    if (bus_active) psel[idx_q] = 1'b1;
  end

endmodule

// File: tb/tb_apb_requester_mux.sv
// Directed bench: a 4-slave instance for normal/timeout/error/reset cases and a 3-slave
// instance for the address decode error.
module tb_apb_requester_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         preset;
  logic         req_valid, req_ready, req_write;
  logic [31:0]  req_addr, req_wdata;
  logic [3:0]   req_strb;
  logic [2:0]   req_prot;
  logic         rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0]  rsp_rdata;
  logic [31:0]  paddr, pwdata;
  logic         pwrite, penable;
  logic [3:0]   pstrb;
  logic [2:0]   pprot;
  logic [3:0]   psel;
  logic [127:0] prdata;
  logic [3:0]   pready, pslverr;
  logic [3:0]   bg_ready, bg_err;

  logic         d3_req_valid, d3_req_ready;
  logic [31:0]  d3_req_addr;
  logic         d3_rsp_valid, d3_rsp_err, d3_rsp_timeout;
  logic [31:0]  d3_rsp_rdata;
  logic [31:0]  d3_paddr, d3_pwdata;
  logic         d3_pwrite, d3_penable;
  logic [3:0]   d3_pstrb;
  logic [2:0]   d3_pprot;
  logic [2:0]   d3_psel;
  logic [95:0]  d3_prdata;
  logic [2:0]   d3_pready, d3_pslverr;

  apb_requester_mux dut (
    .pclk(clk), .preset(preset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .penable(penable), .psel(psel), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  apb_requester_mux #(.NUM_SLAVES(3)) dut3 (
    .pclk(clk), .preset(preset),
    .req_valid(d3_req_valid), .req_ready(d3_req_ready), .req_write(req_write),
    .req_addr(d3_req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .rsp_valid(d3_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(d3_rsp_rdata),
    .rsp_err(d3_rsp_err), .rsp_timeout(d3_rsp_timeout),
    .paddr(d3_paddr), .pwrite(d3_pwrite), .pwdata(d3_pwdata), .pstrb(d3_pstrb),
    .pprot(d3_pprot), .penable(d3_penable), .psel(d3_psel), .prdata(d3_prdata),
    .pready(d3_pready), .pslverr(d3_pslverr)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  // Issues one command to the 4-slave instance; the target raises pready on access
  // cycle waits+1 (never if waits < 0) and asserts pslverr on its non-ready cycles.
  task automatic xfer(input logic wr, input logic [31:0] addr, input int slave,
                      input int waits, input logic serr,
                      output int lat, output int n_acc, output int n_setup,
                      output logic stable);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    tick();
    req_valid = 1'b0;
    lat = 1; n_acc = 0; n_setup = 0; stable = 1'b1;
    while (!rsp_valid && lat < 60) begin
      if (psel != 4'(1 << slave) || paddr != addr || pwrite != wr || pwdata != req_wdata ||
          pstrb != req_strb || pprot != req_prot) stable = 1'b0;
      if (psel != 4'b0 && !penable) n_setup++;
      if (penable) n_acc++;
      pready  = bg_ready;
      pslverr = bg_err;
      pslverr[slave] = 1'b1;
      if (penable && n_acc == waits + 1) begin
        pready[slave]  = 1'b1;
        pslverr[slave] = serr;
      end
      tick();
      lat++;
    end
    pready  = '0;
    pslverr = '0;
    check("xfer_rsp_valid", rsp_valid, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   lat, nacc, nset;
    logic stable, ok;

    preset = 1'b1;
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_strb = '0; req_prot = '0;
    rsp_ready = 0; prdata = '0; pready = '0; pslverr = '0; bg_ready = '0; bg_err = '0;
    d3_req_valid = 0; d3_req_addr = '0; d3_prdata = '0; d3_pready = 3'b111; d3_pslverr = '0;
    repeat (3) tick();
    preset = 1'b0;

    // Reset state
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_pwrite", pwrite, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_pstrb_pprot", {pstrb, pprot}, 0);
    check("rst_rsp", {rsp_valid, rsp_err, rsp_timeout}, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_req_ready", req_ready, 1);

    // Zero-wait write to slave 2
    req_wdata = 32'hA5A5_0001; req_strb = 4'hF; req_prot = 3'b010;
    prdata[64 +: 32] = 32'h1234_5678;
    xfer(1'b1, 32'h0000_2004, 2, 0, 1'b0, lat, nacc, nset, stable);
    check("wr_latency", lat, 3);
    check("wr_access_cycles", nacc, 1);
    check("wr_setup_cycles", nset, 1);
    check("wr_bus_stable", stable, 1);
    check("wr_rsp_err_to", {rsp_err, rsp_timeout}, 0);
    check("wr_rsp_rdata", rsp_rdata, 0);
    check("wr_resp_bus_idle", {psel, penable, pwrite}, 0);
    check("wr_resp_paddr_hold", paddr, 32'h0000_2004);
    check("wr_resp_pwdata_hold", pwdata, 32'hA5A5_0001);
    finish_rsp();
    check("wr_after_rsp", {rsp_valid, req_ready}, 2'b01);

    // Read slave 1 with 3 wait states; slave 0 chatters pready/pslverr
    req_strb = 4'h0; req_prot = 3'b000; req_wdata = 32'h0;
    prdata[32 +: 32] = 32'hDEAD_BEEF;
    prdata[0 +: 32]  = 32'h1111_1111;
    bg_ready = 4'b0001; bg_err = 4'b0001;
    xfer(1'b0, 32'h0000_1000, 1, 3, 1'b0, lat, nacc, nset, stable);
    bg_ready = '0; bg_err = '0;
    check("rd_access_cycles", nacc, 4);
    check("rd_latency", lat, 6);
    check("rd_bus_stable", stable, 1);
    check("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    check("rd_rsp_err_to", {rsp_err, rsp_timeout}, 0);
    finish_rsp();

    // Read slave 3, never ready
    prdata[96 +: 32] = 32'hCAFE_0003;
    xfer(1'b0, 32'h0000_3000, 3, -1, 1'b0, lat, nacc, nset, stable);
    check("to_access_cycles", nacc, 16);
    check("to_latency", lat, 18);
    check("to_rsp_err_to", {rsp_err, rsp_timeout}, 2'b11);
    check("to_rsp_rdata", rsp_rdata, 0);
    check("to_bus_idle", {psel, penable}, 0);
    finish_rsp();

    // Slave 0 error response, response stalled for 5 cycles with a new command pending
    prdata[0 +: 32] = 32'h0BAD_F00D;
    xfer(1'b0, 32'h0000_0000, 0, 0, 1'b1, lat, nacc, nset, stable);
    check("err_latency", lat, 3);
    check("err_rsp_rdata", rsp_rdata, 32'h0BAD_F00D);
    req_valid = 1'b1;
    req_addr  = 32'h0000_1000;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!rsp_valid || !rsp_err || rsp_timeout || req_ready || psel != 4'b0 ||
          rsp_rdata != 32'h0BAD_F00D) ok = 1'b0;
      tick();
    end
    check("err_stall_stable", ok, 1);
    req_valid = 1'b0;
    finish_rsp();
    check("err_after_rsp", {rsp_valid, req_ready}, 2'b01);

    // Decode error on the 3-slave instance
    d3_req_valid = 1'b1;
    d3_req_addr  = 32'h0000_3000;
    tick();
    d3_req_valid = 1'b0;
    check("dec_rsp_valid_n1", d3_rsp_valid, 1);
    check("dec_no_bus", {d3_psel, d3_penable}, 0);
    check("dec_rsp_err_to", {d3_rsp_err, d3_rsp_timeout}, 2'b10);
    check("dec_rsp_rdata", d3_rsp_rdata, 0);
    check("dec_req_ready", d3_req_ready, 0);
    finish_rsp();
    check("dec_after_rsp", {d3_rsp_valid, d3_req_ready}, 2'b01);

    // Reset in the middle of an ACCESS phase
    req_write = 1'b0;
    req_addr  = 32'h0000_3000;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    check("rst_mid_in_access", {psel, penable}, 5'b10001);
    preset = 1'b1;
    tick();
    check("rst_mid_bus", {psel, penable, rsp_valid}, 0);
    check("rst_mid_paddr", paddr, 0);
    preset = 1'b0;
    check("rst_mid_req_ready", req_ready, 1);
    tick();
    check("rst_mid_no_rsp", {rsp_valid, req_ready}, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
